// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Oversample positions of the three votes inside a bit.
  function automatic int samp_lo(input int prescale);
    return prescale / 2 - 1;
  endfunction

  function automatic int samp_mid(input int prescale);
    return prescale / 2;
  endfunction

  function automatic int samp_hi(input int prescale);
    return prescale / 2 + 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit oversample counter and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx_sdata,
  input  logic i_tick,
  input  logic i_cnt_clr,     // hold the counter at 0 (receiver idle)
  output logic o_rx_s,
  output logic o_voted,
  output logic o_bit_done,
  output logic o_sample_done
);

  localparam int CNT_W    = $clog2(PRESCALE);
  localparam int SAMP_LO  = samp_lo(PRESCALE);
  localparam int SAMP_MID = samp_mid(PRESCALE);
  localparam int SAMP_HI  = samp_hi(PRESCALE);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_lo_q, s_lo_d;
  logic             s_mid_q, s_mid_d;

  assign o_rx_s = sync_q[1];

  // Next-state for synchronizer, tick counter and the two early vote samples.
  always_comb begin
    sync_d  = {sync_q[0], i_rx_sdata};
    cnt_d   = cnt_q;
    s_lo_d  = s_lo_q;
    s_mid_d = s_mid_q;
    if (i_tick) begin
      if (i_cnt_clr || cnt_q == CNT_W'(PRESCALE - 1)) cnt_d = '0;
      else                                            cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(SAMP_LO))  s_lo_d  = o_rx_s;
      if (cnt_q == CNT_W'(SAMP_MID)) s_mid_d = o_rx_s;
    end
  end

  // The third vote is the live line at SAMP_HI, so the result is ready on that tick.
  always_comb begin
    o_voted       = (s_lo_q & s_mid_q) | (s_lo_q & o_rx_s) | (s_mid_q & o_rx_s);
    o_bit_done    = i_tick & ~i_cnt_clr & (cnt_q == CNT_W'(PRESCALE - 1));
    o_sample_done = i_tick & ~i_cnt_clr & (cnt_q == CNT_W'(SAMP_HI));
  end

  // Sampler state; synchronizer resets to the idle-high line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      s_lo_q  <= 1'b1;
      s_mid_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      s_lo_q  <= s_lo_d;
      s_mid_q <= s_mid_d;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive stage: frame FSM, LSB-first shift register, parity/stop checks.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 32,
  parameter int PAR_EN     = 1,
  parameter int PAR_TYPE   = 0
) (
  input  logic                  i_uart_clk,
  input  logic                  i_uart_rst_n,
  input  logic                  i_rx_sdata,
  input  logic                  i_rx_tick,
  output logic [DATA_WIDTH-1:0] o_rx_pdata,
  output logic                  o_rx_valid,
  output logic                  o_rx_par_err,
  output logic                  o_rx_stop_err,
  output logic                  o_rx_busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic rx_s, voted, bit_done, sample_done;

  rx_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  par_bad_q, par_bad_d;
  logic                  prev_q, prev_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .i_clk         (i_uart_clk),
    .i_rst_n       (i_uart_rst_n),
    .i_rx_sdata    (i_rx_sdata),
    .i_tick        (i_rx_tick),
    .i_cnt_clr     (state_q == IDLE),
    .o_rx_s        (rx_s),
    .o_voted       (voted),
    .o_bit_done    (bit_done),
    .o_sample_done (sample_done)
  );

  // Frame FSM: next state, data capture, parity flag and one-clock result strobes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    pdata_d   = pdata_q;
    par_bad_d = par_bad_q;
    prev_d    = prev_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;
    if (i_rx_tick) begin
      prev_d = rx_s;
      unique case (state_q)
        IDLE: begin
          // Needs a high sample before the low one, so a held-low line never restarts.
          if (!rx_s && prev_q) begin
            state_d   = START;
            par_bad_d = 1'b0;
          end
        end
        START: begin
          if (sample_done && voted) state_d = IDLE;
          else if (bit_done) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
        DATA: begin
          if (sample_done) shreg_d = {voted, shreg_q[DATA_WIDTH-1:1]};
          if (bit_done) begin
            if (idx_q == IDX_W'(DATA_WIDTH - 1)) state_d = (PAR_EN != 0) ? PARITY : STOP;
            else                                 idx_d   = idx_q + 1'b1;
          end
        end
        PARITY: begin
          if (sample_done) par_bad_d = voted ^ (^shreg_q) ^ (PAR_TYPE != PAR_EVEN);
          if (bit_done)    state_d   = STOP;
        end
        STOP: begin
          // Leave at mid-bit so the next start edge has half a bit of margin.
          if (sample_done) begin
            state_d = IDLE;
            if (!voted)         serr_d = 1'b1;
            else if (par_bad_q) perr_d = 1'b1;
            else begin
              valid_d = 1'b1;
              pdata_d = shreg_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shreg_q   <= '0;
      pdata_q   <= '0;
      par_bad_q <= 1'b0;
      prev_q    <= 1'b1;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      pdata_q   <= pdata_d;
      par_bad_q <= par_bad_d;
      prev_q    <= prev_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  assign o_rx_pdata    = pdata_q;
  assign o_rx_valid    = valid_q;
  assign o_rx_par_err  = perr_q;
  assign o_rx_stop_err = serr_q;
  assign o_rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer (8 data bits, x32 oversample, even parity).
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tick = 1'b1;
  logic [7:0] pdata;
  logic       valid, perr, serr, busy;

  int checks = 0;
  int failures = 0;

  // Strobe monitor state (written only by the monitor process).
  int         n_valid = 0, n_perr = 0, n_serr = 0;
  int         busy_bad = 0, overlap = 0;
  logic [7:0] got[$];

  uart_rx_deserializer #(
    .DATA_WIDTH(8), .PRESCALE(32), .PAR_EN(1), .PAR_TYPE(0)
  ) dut (
    .i_uart_clk   (clk),
    .i_uart_rst_n (rst_n),
    .i_rx_sdata   (rx),
    .i_rx_tick    (tick),
    .o_rx_pdata   (pdata),
    .o_rx_valid   (valid),
    .o_rx_par_err (perr),
    .o_rx_stop_err(serr),
    .o_rx_busy    (busy)
  );

  always #5 clk = ~clk;

  // Count strobes mid-cycle; a strobe longer than one clock counts more than once.
  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      got.push_back(pdata);
      if (busy) busy_bad <= busy_bad + 1;
    end
    if (perr) n_perr <= n_perr + 1;
    if (serr) n_serr <= n_serr + 1;
    if ((32'(valid) + 32'(perr) + 32'(serr)) > 1) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the line at b for n clocks; each call starts just after a rising edge.
  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame; flip >= 0 inverts one clock at the centre of that data bit.
  task automatic send(input logic [7:0] d, input logic par, input logic stop, input int flip);
    drive(1'b0, 32);
    for (int i = 0; i < 8; i++) begin
      if (i == flip) begin
        drive(d[i], 17);
        drive(~d[i], 1);
        drive(d[i], 14);
      end else drive(d[i], 32);
    end
    drive(par, 32);
    drive(stop, 32);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pdata", 32'(pdata), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);
    chk("rst_serr", 32'(serr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 64);

    // Good frame
    send(8'hA5, 1'b0, 1'b1, -1);
    drive(1'b1, 16);
    chk("a5_valid_cnt", n_valid, 1);
    chk("a5_pdata", 32'(pdata), 32'hA5);
    chk("a5_err_cnt", n_perr + n_serr, 0);
    chk("a5_busy_low", 32'(busy), 32'h0);

    // Parity error keeps the old byte
    send(8'h3C, 1'b1, 1'b1, -1);
    drive(1'b1, 16);
    chk("3c_perr_cnt", n_perr, 1);
    chk("3c_valid_cnt", n_valid, 1);
    chk("3c_pdata_held", 32'(pdata), 32'hA5);

    // Stop error followed by a 40-bit break
    send(8'h5A, 1'b0, 1'b0, -1);
    drive(1'b0, 40 * 32);
    chk("brk_serr_cnt", n_serr, 1);
    chk("brk_busy", 32'(busy), 32'h0);
    drive(1'b1, 64);
    chk("brk_serr_after", n_serr, 1);
    chk("brk_other_cnt", n_valid + n_perr, 2);

    // Short glitch is rejected, then a normal frame
    drive(1'b0, 10);
    drive(1'b1, 64);
    chk("glitch_busy", 32'(busy), 32'h0);
    chk("glitch_strobes", n_valid + n_perr + n_serr, 3);
    send(8'hFF, 1'b0, 1'b1, -1);
    drive(1'b1, 16);
    chk("ff_valid_cnt", n_valid, 2);
    chk("ff_pdata", 32'(pdata), 32'hFF);

    // Back-to-back frames, third one with a single flipped vote sample
    send(8'h01, 1'b1, 1'b1, -1);
    send(8'h80, 1'b1, 1'b1, -1);
    send(8'h55, 1'b0, 1'b1, 3);
    drive(1'b1, 64);
    chk("b2b_valid_cnt", n_valid, 5);
    chk("b2b_err_cnt", n_perr + n_serr, 2);
    if (got.size() >= 5) begin
      chk("b2b_byte0", 32'(got[2]), 32'h01);
      chk("b2b_byte1", 32'(got[3]), 32'h80);
      chk("b2b_byte2", 32'(got[4]), 32'h55);
    end else begin
      chk("b2b_queue_len", got.size(), 5);
    end

    // Reset during data bit 4 aborts the frame
    drive(1'b0, 32);
    drive(1'b1, 32);
    drive(1'b0, 32);
    drive(1'b1, 32);
    drive(1'b1, 32);
    drive(1'b0, 16);
    rst_n = 1'b0;
    drive(1'b1, 5);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 64);
    chk("mid_rst_pdata", 32'(pdata), 32'h0);
    chk("mid_rst_strobes", n_valid + n_perr + n_serr, 7);
    send(8'hC3, 1'b0, 1'b1, -1);
    drive(1'b1, 16);
    chk("c3_valid_cnt", n_valid, 6);
    chk("c3_pdata", 32'(pdata), 32'hC3);

    chk("busy_during_valid", busy_bad, 0);
    chk("strobe_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
